// File: rtl/toa_pkg.sv
// ============================================================================
// toa_pkg : shared constants for the time-of-arrival encoder
// Rev 1.0
// ============================================================================
`default_nettype none

package toa_pkg;
  localparam int TAPS      = 63;
  localparam int FINE_BINS = 124;
  localparam int FINE_W    = 7;
  localparam int COARSE_W  = 3;
  localparam int IDX_W     = 6;
endpackage

`default_nettype wire

// File: rtl/toa_edge_finder.sv
// ============================================================================
// toa_edge_finder : locates the lowest equal-neighbour pair in a delay-line
// snapshot and counts all such pairs.  Purely combinational.
// Rev 1.0
// ============================================================================
`default_nettype none

module toa_edge_finder
  import toa_pkg::*;
(
  input  logic [TAPS-1:0]  A_i,
  output logic [IDX_W-1:0] p_o,
  output logic             pol_o,
  output logic [IDX_W-1:0] cnt_o,
  output logic             found_o
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    p_o     = '0;
    found_o = 1'b0;
    cnt_o   = '0;
    for (int i = TAPS - 2; i >= 0; i--) begin
      if (A_i[i] == A_i[i+1]) begin
        p_o     = IDX_W'(i);
        found_o = 1'b1;
        cnt_o   = cnt_o + 6'd1;
      end
    end
    pol_o = A_i[p_o];
  end

endmodule

`default_nettype wire

// File: rtl/toa_encoder.sv
// ============================================================================
// toa_encoder : ring delay-line snapshot -> calibrated fine phase plus coarse
// phase, with bubble/counter consistency flag.  One-cycle registered latency.
// Rev 1.0
// ============================================================================
`default_nettype none

module toa_encoder
  import toa_pkg::*;
#(
  parameter int TAPS_P      = TAPS,
  parameter int FINE_BINS_P = FINE_BINS
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [TAPS_P-1:0]   A,
  input  logic [2:0]          level,
  input  logic [COARSE_W-1:0] counterA,
  input  logic [COARSE_W-1:0] counterB,
  input  logic [FINE_W-1:0]   offset,
  input  logic                selRawCode,
  output logic [COARSE_W-1:0] outputCoarsePhase,
  output logic [FINE_W-1:0]   outputFinePhase,
  output logic                errorFlag
);

  logic [IDX_W-1:0]    p;
  logic                pol;
  logic [IDX_W-1:0]    cnt;
  logic                found;

  logic [FINE_W-1:0]   raw;
  logic [COARSE_W-1:0] sel;
  logic                off_bad;
  logic [FINE_W-1:0]   off_eff;
  logic [FINE_W:0]     diff;
  logic                borrow;
  logic [2:0]          lvl_eff;
  logic [COARSE_W-1:0] cnt_skew;

  logic [COARSE_W-1:0] coarse_d, coarse_q;
  logic [FINE_W-1:0]   fine_d,   fine_q;
  logic                err_d,    err_q;

  toa_edge_finder u_edge (
    .A_i     (A),
    .p_o     (p),
    .pol_o   (pol),
    .cnt_o   (cnt),
    .found_o (found)
  );

  always_comb begin
    // 2*p + A[p] is just p with the polarity appended as LSB.
    raw      = found ? {p, pol} : '0;
    sel      = (raw < FINE_W'(TAPS_P - 1)) ? counterA : counterB;
    off_bad  = (offset >= FINE_W'(FINE_BINS_P));
    off_eff  = off_bad ? '0 : offset;
    diff     = {1'b0, raw} - {1'b0, off_eff};
    borrow   = diff[FINE_W];
    lvl_eff  = (level == 3'd0) ? 3'd1 : level;
    cnt_skew = counterA - counterB;

    if (selRawCode) begin
      fine_d   = raw;
      coarse_d = sel;
    end else if (borrow) begin
      // Wrapped into the previous coarse period.
      fine_d   = diff[FINE_W-1:0] + FINE_W'(FINE_BINS_P);
      coarse_d = sel - 3'd1;
    end else begin
      fine_d   = diff[FINE_W-1:0];
      coarse_d = sel;
    end

    err_d = !found
         || (cnt > {3'b000, lvl_eff})
         || (cnt_skew > 3'd1)
         || off_bad;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      coarse_q <= '0;
      fine_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      coarse_q <= coarse_d;
      fine_q   <= fine_d;
      err_q    <= err_d;
    end
  end

  assign outputCoarsePhase = coarse_q;
  assign outputFinePhase   = fine_q;
  assign errorFlag         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_toa_encoder.sv
// ============================================================================
// tb_toa_encoder : randomized bench for toa_encoder against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_toa_encoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [62:0] A = '0;
  logic [2:0]  level = 3'd1;
  logic [2:0]  counterA = '0;
  logic [2:0]  counterB = '0;
  logic [6:0]  offset = '0;
  logic        selRawCode = 1'b0;
  logic [2:0]  outputCoarsePhase;
  logic [6:0]  outputFinePhase;
  logic        errorFlag;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk = 1'b0;

  toa_encoder dut (
    .clk               (clk),
    .rstn              (rstn),
    .A                 (A),
    .level             (level),
    .counterA          (counterA),
    .counterB          (counterB),
    .offset            (offset),
    .selRawCode        (selRawCode),
    .outputCoarsePhase (outputCoarsePhase),
    .outputFinePhase   (outputFinePhase),
    .errorFlag         (errorFlag)
  );

  always #5 clk = ~clk;

  // Expected {coarse, fine, err} straight from the encoding rules.
  function automatic logic [10:0] model(input logic [62:0] a, input logic [2:0] lv,
                                        input logic [2:0] ca, input logic [2:0] cb,
                                        input logic [6:0] off, input logic sr);
    int cnt, p, raw, sel, o, f, c, lvl;
    logic e;
    cnt = 0;
    p   = -1;
    for (int i = 0; i < 62; i++) begin
      if (a[i] == a[i+1]) begin
        cnt++;
        if (p < 0) p = i;
      end
    end
    raw = (p < 0) ? 0 : 2 * p + int'(a[p]);
    sel = (raw < 62) ? int'(ca) : int'(cb);
    o   = (off >= 7'd124) ? 0 : int'(off);
    if (sr) begin
      f = raw; c = sel;
    end else if (raw >= o) begin
      f = raw - o; c = sel;
    end else begin
      f = raw - o + 124; c = (sel + 7) % 8;
    end
    lvl = (lv == 3'd0) ? 1 : int'(lv);
    e = (cnt == 0) || (cnt > lvl) || ((((int'(ca) - int'(cb)) + 8) % 8) > 1) || (off >= 7'd124);
    return {3'(c), 7'(f), e};
  endfunction

  // Alternating pattern starting with b0 at bit 0; a set mask bit i repeats bit i into bit i+1.
  function automatic logic [62:0] mk(input logic [61:0] mask, input logic b0);
    logic [62:0] r;
    logic v;
    v = b0;
    for (int i = 0; i < 63; i++) begin
      r[i] = v;
      if (i < 62) begin
        if (!mask[i]) v = ~v;
      end
    end
    return r;
  endfunction

  // Per-cycle compare against the model.
  initial begin
    logic [10:0] expv;
    logic armed;
    forever begin
      @(posedge clk);
      armed = chk;
      expv  = rstn ? model(A, level, counterA, counterB, offset, selRawCode) : 11'd0;
      @(negedge clk);
      if (armed) begin
        n_checks++;
        if ({outputCoarsePhase, outputFinePhase, errorFlag} !== expv) begin
          n_fail++;
          $display("FAIL model @%0t: got c=%0d f=%0d e=%0d, expected c=%0d f=%0d e=%0d",
                   $time, outputCoarsePhase, outputFinePhase, errorFlag,
                   expv[10:8], expv[7:1], expv[0]);
        end
      end
    end
  end

  task automatic apply(input logic [62:0] a, input logic [2:0] lv, input logic [2:0] ca,
                       input logic [2:0] cb, input logic [6:0] off, input logic sr);
    @(negedge clk);
    rstn = 1'b1; A = a; level = lv; counterA = ca; counterB = cb; offset = off; selRawCode = sr;
  endtask

  task automatic lit(input string name, input int c, input int f, input int e);
    @(posedge clk);
    #1;
    n_checks++;
    if (int'(outputCoarsePhase) != c || int'(outputFinePhase) != f || int'(errorFlag) != e) begin
      n_fail++;
      $display("FAIL %s: got c=%0d f=%0d e=%0d, expected c=%0d f=%0d e=%0d",
               name, outputCoarsePhase, outputFinePhase, errorFlag, c, f, e);
    end
  endtask

  initial begin
    logic [62:0] a1, a2, a0, a3;
    logic [61:0] m;
    a1 = mk(62'd1 << 50, 1'b1);
    a2 = mk(62'd1 << 59, 1'b1);
    a0 = mk(62'd0, 1'b1);
    a3 = mk((62'd1 << 10) | (62'd1 << 40), 1'b1);

    @(negedge clk);
    rstn = 1'b0; chk = 1'b1;
    A = {$urandom, $urandom}; counterA = 3'd5; counterB = 3'd1; offset = 7'd33; selRawCode = 1'b1;
    lit("reset_1", 0, 0, 0);
    lit("reset_2", 0, 0, 0);

    apply(a1, 3'd1, 3'd2, 3'd0, 7'd0,   1'b0); lit("pair50_mismatch", 0, 101, 1);
    apply(a2, 3'd1, 3'd2, 3'd2, 7'd0,   1'b0); lit("pair59",          2, 118, 0);
    apply(a2, 3'd1, 3'd2, 3'd2, 7'd120, 1'b0); lit("offset_wrap",     1, 122, 0);
    apply(a2, 3'd1, 3'd2, 3'd2, 7'd120, 1'b1); lit("raw_code",        2, 118, 0);
    apply(a0, 3'd1, 3'd2, 3'd2, 7'd0,   1'b0); lit("no_pair",         2, 0,   1);
    apply(a3, 3'd1, 3'd2, 3'd2, 7'd0,   1'b0); lit("two_pairs_lvl1",  2, 21,  1);
    apply(a3, 3'd2, 3'd2, 3'd2, 7'd0,   1'b0); lit("two_pairs_lvl2",  2, 21,  0);
    apply(a2, 3'd1, 3'd3, 3'd2, 7'd124, 1'b0); lit("offset_invalid",  2, 118, 1);
    apply(a1, 3'd0, 3'd5, 3'd4, 7'd0,   1'b0); lit("level0_skew1",    4, 101, 0);
    apply(a1, 3'd1, 3'd5, 3'd4, 7'd101, 1'b0); lit("offset_equal",    4, 0,   0);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0) begin
        A = {$urandom, $urandom};
      end else begin
        m = '0;
        for (int k = $urandom_range(0, 3); k > 0; k--) m[$urandom_range(0, 61)] = 1'b1;
        A = mk(m, 1'($urandom));
      end
      level    = 3'($urandom);
      counterA = 3'($urandom);
      counterB = ($urandom_range(0, 3) == 0) ? 3'($urandom) : counterA - 3'($urandom_range(0, 1));
      offset   = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(124, 127)) : 7'($urandom_range(0, 123));
      selRawCode = ($urandom_range(0, 3) == 0);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/toa_encoder.md
Name: toa_encoder

Overview:
- Time-of-arrival encoder for the TDC datapath.
- Converts a 63-tap ring delay-line snapshot into a 7-bit fine phase, and merges it with one of two 3-bit coarse counters into a 3-bit coarse phase.
- Flags bubble/counter inconsistencies.
- Sits between the delay-line sampling latches and the hit-data formatter; single clock domain, registered outputs.

Parameters:
- TAPS, 63, number of delay-line taps (width of A).
- FINE_BINS, 124, fine bins per coarse period (2*(TAPS-1)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  synchronous reset, active-low.
- A  in  63  raw delay-line snapshot; idle pattern alternates 0/1 (bit i = ~bit i+1).
- level  in  3  bubble tolerance: max number of equal-neighbour pairs accepted; 0 treated as 1.
- counterA  in  3  coarse counter, early-sampled copy.
- counterB  in  3  coarse counter, late-sampled copy.
- offset  in  7  fine-phase calibration offset, valid 0..123.
- selRawCode  in  1  1 = output uncalibrated raw fine code; 0 = offset-corrected.
- outputCoarsePhase  out  3  coarse phase.
- outputFinePhase  out  7  fine phase, 0..123.
- errorFlag  out  1  encoding error for this sample.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rstn=0 sampled at the clk edge). While reset is active, all outputs go to 0 on that edge.
- Latency: combinational encode; outputs are registered. Inputs sampled at edge N appear at the outputs after edge N; latency is 1 cycle, new result every cycle, no handshake.
- Edge detect: e[i] = (A[i] == A[i+1]) for i = 0..61. No wrap pair.
- Pair count: cnt = popcount(e).
- Edge position: p = lowest i with e[i] = 1.
- Raw fine code: raw = 2*p + A[p] (range 0..123). If cnt = 0, raw = 0.
- Counter select: raw < 62 uses counterA; otherwise counterB. The result is sel.
- selRawCode = 1: fine = raw; coarse = sel.
- selRawCode = 0, raw >= offset: fine = raw - offset; coarse = sel.
- selRawCode = 0, raw < offset: fine = raw - offset + 124; coarse = (sel - 1) mod 8.
- offset >= 124 behaves as offset = 0 and sets errorFlag.
- errorFlag = 1 if any of the following hold:
  - cnt = 0;
  - cnt > max(level, 1);
  - (counterA - counterB) mod 8 is not in {0, 1};
  - offset >= 124.
- On error, fine and coarse are still computed per the rules above (not forced to 0).
- Reset mid-stream: the next output after reset release reflects the inputs sampled at the first non-reset edge.

Decomposition:
- Shared package toa_pkg: constants TAPS = 63, FINE_BINS = 124, FINE_W = 7, COARSE_W = 3.
- One sub-module: toa_edge_finder. It is combinational, takes A[62:0] and returns p (6 bits), polarity A[p], cnt (6 bits) and a found flag.
- Top level holds counter select, offset subtraction with borrow, error logic and output registers.

Test Plan:
- Reset: hold rstn = 0 for 2 edges with arbitrary inputs -> coarse = 0, fine = 0, errorFlag = 0.
- A = 63'b010_1010_1010_1101_0101_..._0101, counterA = 2, counterB = 0, level = 1, offset = 0, selRawCode = 0 -> pair at p = 50, fine = 101, coarse = 0 (counterB), errorFlag = 1 (counter mismatch of 2).
- A = 63'b010_0101_0101_..._0101, counterA = 2, counterB = 2, same settings -> p = 59, fine = 118, coarse = 2, errorFlag = 0.
- Second vector with offset = 120 and counters = 2, selRawCode = 0 -> fine = 122, coarse = 1, errorFlag = 0.
- Same with selRawCode = 1 -> fine = 118, coarse = 2.
- Pure alternating A (no pair) -> errorFlag = 1.
- A with two pairs and level = 1 -> errorFlag = 1.
- A with two pairs and level = 2 -> errorFlag = 0; fine taken from the lower pair.
